// File: rtl/pio_edge_irq.sv
// Avalon-MM input PIO with per-bit debounce, selectable edge capture (W1C),
// sticky overflow of missed edges and a single masked interrupt line.
module pio_edge_irq #(
    parameter int W          = 6,
    parameter int DB_W       = 16,
    parameter int DB_DEFAULT = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [2:0]    address,
    input  logic          chipselect,
    input  logic          write_n,
    input  logic [31:0]   writedata,
    input  logic [W-1:0]  in_port,
    output logic [31:0]   readdata,
    output logic          irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_MODE    = 3'd1;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_DEBOUNCE = 3'd4;
    localparam logic [2:0] ADDR_OVF     = 3'd5;

    logic [W-1:0]    sync1_reg;
    logic [W-1:0]    sync2_reg;
    logic [W-1:0]    stable_reg;
    logic [W-1:0]    stable_next;
    logic [DB_W-1:0] cnt_reg  [W];
    logic [DB_W-1:0] cnt_next [W];
    logic [2*W-1:0]  mode_reg;
    logic [W-1:0]    mask_reg;
    logic [W-1:0]    capture_reg;
    logic [W-1:0]    capture_next;
    logic [W-1:0]    ovf_reg;
    logic [W-1:0]    ovf_next;
    logic [DB_W-1:0] db_n_reg;

    logic [W-1:0]    commit;
    logic [W-1:0]    qual;
    logic [W-1:0]    clr_cap;
    logic [W-1:0]    clr_ovf;
    logic [W-1:0]    ovf_event;
    logic            wr_en;
    logic [31:0]     rd_mux;

    assign wr_en   = chipselect & ~write_n;
    assign clr_cap = (wr_en && address == ADDR_CAPTURE) ? writedata[W-1:0] : '0;
    assign clr_ovf = (wr_en && address == ADDR_OVF)     ? writedata[W-1:0] : '0;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            // A commit happens once the disagreement has lasted past the threshold.
            assign commit[gi]      = (sync2_reg[gi] != stable_reg[gi]) && (cnt_reg[gi] >= db_n_reg);
            assign stable_next[gi] = commit[gi] ? sync2_reg[gi] : stable_reg[gi];
            assign cnt_next[gi]    = ((sync2_reg[gi] == stable_reg[gi]) || commit[gi]) ?
                                     '0 : cnt_reg[gi] + DB_W'(1);
            assign qual[gi]        = commit[gi] &
                                     (sync2_reg[gi] ? mode_reg[2*gi] : mode_reg[2*gi+1]);
        end
    endgenerate

    // A new event always wins over a clear landing on the same edge.
    assign ovf_event    = qual & capture_reg & ~clr_cap;
    assign capture_next = (capture_reg & ~clr_cap) | qual;
    assign ovf_next     = (ovf_reg & ~clr_ovf) | ovf_event;

    assign irq = |(capture_reg & mask_reg);

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:     rd_mux[W-1:0]    = stable_reg;
            ADDR_MODE:     rd_mux[2*W-1:0]  = mode_reg;
            ADDR_MASK:     rd_mux[W-1:0]    = mask_reg;
            ADDR_CAPTURE:  rd_mux[W-1:0]    = capture_reg;
            ADDR_DEBOUNCE: rd_mux[DB_W-1:0] = db_n_reg;
            ADDR_OVF:      rd_mux[W-1:0]    = ovf_reg;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_reg   <= '0;
            sync2_reg   <= '0;
            stable_reg  <= '0;
            for (int i = 0; i < W; i++) cnt_reg[i] <= '0;
            mode_reg    <= {W{2'b01}};
            mask_reg    <= '0;
            capture_reg <= '0;
            ovf_reg     <= '0;
            db_n_reg    <= DB_W'(DB_DEFAULT);
            readdata    <= '0;
        end else begin
            sync1_reg   <= in_port;
            sync2_reg   <= sync1_reg;
            stable_reg  <= stable_next;
            for (int i = 0; i < W; i++) cnt_reg[i] <= cnt_next[i];
            capture_reg <= capture_next;
            ovf_reg     <= ovf_next;
            readdata    <= rd_mux;
            if (wr_en) begin
                case (address)
                    ADDR_MODE:     mode_reg <= writedata[2*W-1:0];
                    ADDR_MASK:     mask_reg <= writedata[W-1:0];
                    ADDR_DEBOUNCE: db_n_reg <= writedata[DB_W-1:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/pio_edge_irq.md
# pio_edge_irq

Parametrised successor to the team's fixed 6-bit input PIO with edge capture. It is an Avalon-MM slave that presents W input pins to the Nios II. New in this generation:
- per-bit debounce with a software-set threshold, aimed at the keypad and pushbutton inputs;
- per-bit edge-type selection;
- write-1-to-clear edge capture;
- a sticky overflow register for missed edges.

It sits between the board pins and the Nios II system interconnect, and drives one IRQ line.

## Interface
Parameters:
- W, 6: number of input bits; legal range 1..16.
- DB_W, 16: width of the debounce counter and of the threshold register.
- DB_DEFAULT, 0: reset value of the debounce threshold.

Ports:
- clk  input  1  system clock; the block has one clock.
- reset_n  input  1  reset; synchronous, active-low, sampled on the rising edge of clk.
- address  input  3  register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  W  asynchronous pin inputs.
- readdata  output  32  registered read data.
- irq  output  1  interrupt request, active-high.

## Operation
Register map (a W-bit register occupies bits [W-1:0]; all unused bits read 0; writes take effect only when chipselect=1 and write_n=0):
- 0 DATA (read-only): the debounced input vector `stable`.
- 1 EDGE_MODE (read/write, 2W bits): bits {2i+1,2i} select the edge type for bit i.
  - 00 = none, 01 = rising, 10 = falling, 11 = both.
  - Reset value is 01 for every bit.
- 2 IRQ_MASK (read/write): reset value 0.
- 3 EDGE_CAPTURE (write-1-to-clear): writing 1 to bit i clears bit i; writing 0 leaves it unchanged.
- 4 DEBOUNCE (read/write, DB_W bits): the threshold N. Reset value is DB_DEFAULT.
- 5 OVERFLOW (write-1-to-clear): sticky per-bit flag.
- 6 and 7 read 0. Writes to them, and to DATA, are ignored.

Input path, per bit i:
- A two-flop synchronizer produces sync[i]. Both flops reset to 0.
- Debounce counter cnt[i] (DB_W bits), updated each cycle:
  - if sync==stable: cnt<=0;
  - else if cnt>=N: stable<=sync and cnt<=0 (this is a commit);
  - else: cnt<=cnt+1.
- N=0 is a legal bypass: stable follows sync one cycle later.
- A rising edge event is a commit with sync=1; a falling edge event is a commit with sync=0.
- An event is qualified only if the EDGE_MODE bits for bit i select it.

Capture rules, per bit, all taking effect on the same edge as the commit:
- A qualified event sets capture[i].
- A qualified event while capture[i]=1, and with no W1C to bit i in the same cycle, sets ovf[i].
- If a W1C to capture[i] and a qualified event happen in the same cycle, the event wins: capture[i] ends at 1 and ovf[i] is not set.
- Same rule for OVERFLOW: a W1C to ovf[i] coinciding with an overflow event leaves ovf[i]=1.

Other rules:
- irq = |(capture & mask). It is combinational from registers only.
- Writing DEBOUNCE does not reset the counters. The new N applies from the next cycle, so a counter already >=N commits on that cycle.
- Writing EDGE_MODE or IRQ_MASK does not alter capture.

## Timing
- Reset (synchronous) clears synchronizer, stable, cnt, capture, ovf, mask and readdata. It sets EDGE_MODE to all-01 and DEBOUNCE to DB_DEFAULT.
  - irq=0 and readdata=0 from the first edge with reset_n=0.
  - An input held at 1 through reset produces a rising event after reset. This is intended.
- Reset asserted mid-debounce discards the count. No event is produced from the partial count.
- readdata is registered every cycle from the address mux, independent of chipselect. Read latency is 1 cycle.
- Input latency: a change on in_port that is set up before edge k, and held, commits at edge k+2+N.
  - stable, capture and irq are visible after that edge.
  - A DATA read addressed at edge k+3+N returns the new value.
- A glitch shorter than N+1 sync-domain cycles produces no commit.
- Register writes are visible to a read issued on the next cycle.
- There is no wait-state and no back-pressure; every access completes in one cycle.

## Test plan
- Reset, then N=0 and mask=1 on bit 0. Drive in_port[0] 0->1 before edge k. Required: capture=0x1 and irq=1 after edge k+2; a read of address 3 returns 0x00000001.
- N=4. Pulse in_port[1] high for 3 cycles. Required: no commit and DATA bit1=0. Then hold it high. Required: commit exactly at edge k+6, DATA bit1=1.
- EDGE_MODE bit2=10 (falling only). Drive a 0->1->0 pulse. Required: capture bit2 is set only on the 1->0 commit. Then set mode 11. Required: both edges set capture.
- Two qualified events on bit 3 with no clear in between. Required: OVERFLOW=0x8. Write 0x8 to address 5. Required: OVERFLOW=0.
- W1C to capture bit 0 in the same cycle as a new commit on bit 0. Required: capture bit0 stays 1, ovf bit0 stays 0, irq stays 1.
- Assert reset_n=0 for 1 cycle mid-debounce (cnt=2, N=5). Required: all registers at their reset values and irq=0. With in_port high, exactly one rising event occurs at the 5+2+1 (=8)th edge after reset releases.
